// File: rtl/riscv_core_pkg.sv
// Shared definitions for the core slice: boot-loader states and the pad instruction.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package riscv_core_pkg;

   // addi x0,x0,0 -- the canonical RISC-V no-op
   localparam logic [31:0] NOP_WORD = 32'h00000013;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      PAD  = 3'd2,
      RUN  = 3'd3,
      DONE = 3'd4
   } boot_state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Loads a program into IMEM over valid/ready, pads the tail with NOP, then runs the core for a fixed window.
// Latency: one IMEM write per accepted word or pad slot; core reset releases on the cycle after the last write.
// Backpressure: load_ready is high only while loading; it drops after load_last or once IMEM is full.
module imem_boot_loader #(
   parameter int          XLEN       = 32,
   parameter int          DEPTH      = 64,
   parameter int          ADDR_W     = $clog2(DEPTH),
   parameter int          CNT_W      = 16,
   parameter int          RUN_CYCLES = 30,
   parameter logic [31:0] NOP_WORD   = riscv_core_pkg::NOP_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [XLEN-1:0]   load_data,
   input  logic              load_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [XLEN-1:0]   imem_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded,
   output logic [CNT_W-1:0]  cycle_count
);

   import riscv_core_pkg::*;

   localparam logic [ADDR_W:0]  PTR_LAST = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0]  PTR_ONE  = (ADDR_W+1)'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES-1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   boot_state_t     state;
   // One bit wider than the IMEM address so a full load never wraps silently
   logic [ADDR_W:0] wr_ptr;
   logic            xfer;
   logic            at_last;

   assign load_ready = (state == LOAD);
   assign xfer       = load_valid & load_ready;
   assign at_last    = (wr_ptr == PTR_LAST);
   assign busy       = (state == LOAD) || (state == PAD) || (state == RUN);

   // IMEM write port: program words while loading, NOP fill while padding, idle otherwise
   always_comb begin
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      case (state)
         LOAD: begin
            imem_we    = xfer;
            imem_addr  = wr_ptr[ADDR_W-1:0];
            imem_wdata = load_data;
         end
         PAD: begin
            imem_we    = 1'b1;
            imem_addr  = wr_ptr[ADDR_W-1:0];
            imem_wdata = XLEN'(NOP_WORD);
         end
         default: begin
            imem_we    = 1'b0;
         end
      endcase
   end

   // Sequencer: state, write pointer, counters and status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         words_loaded <= '0;
         cycle_count  <= '0;
         error        <= 1'b0;
         done         <= 1'b0;
         core_rst_n   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // A fresh load puts the core back into reset and clears all status
               if (start) begin
                  state        <= LOAD;
                  wr_ptr       <= '0;
                  words_loaded <= '0;
                  cycle_count  <= '0;
                  error        <= 1'b0;
                  done         <= 1'b0;
                  core_rst_n   <= 1'b0;
               end
            end
            LOAD: begin
               if (xfer) begin
                  wr_ptr       <= wr_ptr + PTR_ONE;
                  words_loaded <= words_loaded + PTR_ONE;
                  if (at_last) begin
                     // IMEM is full: nothing left to pad; no last marker means overflow
                     state      <= RUN;
                     core_rst_n <= 1'b1;
                     error      <= ~load_last;
                  end else if (load_last) begin
                     state <= PAD;
                  end
               end
            end
            PAD: begin
               if (at_last) begin
                  state      <= RUN;
                  core_rst_n <= 1'b1;
               end else begin
                  wr_ptr <= wr_ptr + PTR_ONE;
               end
            end
            RUN: begin
               cycle_count <= cycle_count + CNT_ONE;
               if (cycle_count == CNT_LAST) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for the IMEM boot loader at DEPTH=8 with a 30-cycle run window.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_imem_boot_loader;

   localparam int          XLEN       = 32;
   localparam int          DEPTH      = 8;
   localparam int          ADDR_W     = 3;
   localparam int          CNT_W      = 16;
   localparam int          RUN_CYCLES = 30;
   localparam logic [31:0] NOP        = 32'h00000013;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              load_valid;
   logic              load_ready;
   logic [XLEN-1:0]   load_data;
   logic              load_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [XLEN-1:0]   imem_wdata;
   logic              core_rst_n;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;
   logic [CNT_W-1:0]  cycle_count;

   int checks = 0;
   int errors = 0;
   int n;

   logic [31:0] prog [5] = '{32'h0FF00493, 32'h0AA00513, 32'h00A485B3,
                             32'h00500813, 32'hFFB58593};

   int          log_addr [$];
   logic [31:0] log_data [$];

   imem_boot_loader #(
      .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
      .RUN_CYCLES(RUN_CYCLES), .NOP_WORD(NOP)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_last(load_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // Record every IMEM write as it is committed on the clock edge
   always @(posedge clk) begin
      if (imem_we === 1'b1) begin
         log_addr.push_back(int'(imem_addr));
         log_data.push_back(imem_wdata);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   // Ends on the negedge after the edge that sampled start
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("done_reached", done, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_core_rst_n"}, core_rst_n, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_words_loaded"}, words_loaded, 0);
      check({tag, "_cycle_count"}, cycle_count, 0);
      check({tag, "_load_ready"}, load_ready, 0);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
   endtask

   // Full image expected after loading prog[0..k-1] then NOP padding
   task automatic check_image(input string tag, input int k);
      check({tag, "_write_count"}, log_addr.size(), DEPTH);
      for (int a = 0; a < DEPTH; a++) begin
         if (a < log_addr.size()) begin
            check({tag, "_addr"}, log_addr[a], a);
            check({tag, "_data"}, log_data[a], (a < k) ? prog[a] : NOP);
         end
      end
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Back-to-back stream of five words, then NOP fill and run window
      clear_log();
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 4);
         #1;
         check("t1_ready", load_ready, 1);
         check("t1_addr", imem_addr, i);
         @(negedge clk);
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      for (int a = 5; a < DEPTH; a++) begin
         #1;
         check("t1_pad_we", imem_we, 1);
         check("t1_pad_addr", imem_addr, a);
         check("t1_pad_data", imem_wdata, NOP);
         check("t1_pad_core_rst", core_rst_n, 0);
         @(negedge clk);
      end
      check("t1_run_core_rst", core_rst_n, 1);
      check("t1_run_we", imem_we, 0);
      check("t1_words", words_loaded, 5);
      check("t1_run_busy", busy, 1);
      check("t1_run_cnt0", cycle_count, 0);
      wait_done(n);
      check("t1_run_len", n, RUN_CYCLES);
      check("t1_cycle_count", cycle_count, RUN_CYCLES);
      check("t1_done_busy", busy, 0);
      check("t1_done_core_rst", core_rst_n, 1);
      check_image("t1", 5);

      // Restart from DONE, stream with bubbles, and poke start during PAD/RUN
      clear_log();
      pulse_start();
      check("t5_core_rst", core_rst_n, 0);
      check("t5_done", done, 0);
      check("t5_words", words_loaded, 0);
      check("t5_cycle_count", cycle_count, 0);
      check("t5_ready", load_ready, 1);
      for (int i = 0; i < 5; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 4);
         #1;
         check("t2_we", imem_we, 1);
         check("t2_addr", imem_addr, i);
         @(negedge clk);
         if (i < 4) begin
            repeat (2) begin
               load_valid = 1'b0;
               #1;
               check("t2_bubble_we", imem_we, 0);
               check("t2_bubble_words", words_loaded, i + 1);
               @(negedge clk);
            end
         end
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      start      = 1'b1;
      #1;
      check("t6_pad_addr5", imem_addr, 5);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("t6_pad_addr6", imem_addr, 6);
      check("t6_pad_ready", load_ready, 0);
      check("t6_pad_core_rst", core_rst_n, 0);
      @(negedge clk);
      check("t6_pad_addr7", imem_addr, 7);
      @(negedge clk);
      check("t6_run_cnt0", cycle_count, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("t6_run_cnt1", cycle_count, 1);
      check("t6_run_core_rst", core_rst_n, 1);
      check("t6_run_ready", load_ready, 0);
      check("t6_run_words", words_loaded, 5);
      wait_done(n);
      check("t6_run_rest", n, RUN_CYCLES - 1);
      check_image("t2", 5);

      // Nine words without last: IMEM fills, overflow flagged, no padding
      clear_log();
      pulse_start();
      check("t3_error_clear", error, 0);
      for (int i = 0; i < 9; i++) begin
         load_valid = 1'b1;
         load_data  = 32'h1000_0000 + 32'(i);
         load_last  = 1'b0;
         #1;
         if (i < DEPTH) begin
            check("t3_ready", load_ready, 1);
            check("t3_addr", imem_addr, i);
         end else begin
            check("t3_full_ready", load_ready, 0);
            check("t3_full_we", imem_we, 0);
            check("t3_error", error, 1);
            check("t3_core_rst", core_rst_n, 1);
            check("t3_words", words_loaded, DEPTH);
            check("t3_busy", busy, 1);
         end
         @(negedge clk);
      end
      load_valid = 1'b0;
      check("t3_write_count", log_addr.size(), DEPTH);
      wait_done(n);
      check("t3_error_sticky", error, 1);
      check("t3_cycle_count", cycle_count, RUN_CYCLES);

      // Async reset after three accepted words, then a clean reload
      clear_log();
      pulse_start();
      check("t4_error_clear", error, 0);
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = 1'b0;
         @(negedge clk);
      end
      load_data = prog[3];
      check("t4_words3", words_loaded, 3);
      rst = 1'b0;
      #1;
      check_reset_outputs("t4_midreset");
      @(negedge clk);
      rst        = 1'b1;
      load_valid = 1'b0;
      check("t4_partial_writes", log_addr.size(), 3);
      clear_log();
      @(negedge clk);
      pulse_start();
      load_valid = 1'b1;
      load_data  = prog[0];
      load_last  = 1'b1;
      #1;
      check("t4_first_we", imem_we, 1);
      check("t4_first_addr", imem_addr, 0);
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("t4_first_logged", (log_addr.size() > 0) ? log_addr[0] : -1, 0);
      wait_done(n);
      check("t4_words", words_loaded, 1);
      check_image("t4", 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
